// File: rtl/cache_miss_controller.sv
// Miss-handling engine for the 8-way, 16-set cache: victim selection, optional
// write-back, fetch or store-data capture, then a one-cycle fill of the arrays.
module cache_miss_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        miss_req,
   input  logic [31:0] miss_addr,
   input  logic        miss_is_write,
   input  logic [31:0] miss_wdata,
   input  logic [7:0]  valid_vec,
   input  logic [7:0]  dirty_vec,
   output logic [2:0]  victim_way,
   input  logic [25:0] victim_tag,
   input  logic [31:0] victim_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        fill_we,
   output logic [3:0]  fill_index,
   output logic [7:0]  fill_way_oh,
   output logic [25:0] fill_tag,
   output logic [3:0]  fill_halt_tag,
   output logic [31:0] fill_data,
   output logic        fill_valid,
   output logic        fill_dirty,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE, SELECT, WRITEBACK, FETCH, FILL, DONE
   } state_t;

   state_t      state, state_nxt;

   logic [25:0] tag_q;
   logic [3:0]  idx_q;
   logic        wr_q;
   logic [31:0] wdata_q;
   logic [7:0]  valid_q;
   logic [7:0]  dirty_q;
   logic [2:0]  victim_q;
   logic        from_rr_q;
   logic [25:0] vtag_q;
   logic [31:0] vdata_q;
   logic [31:0] rdata_q;
   logic [2:0]  rr_ptr;

   logic [2:0]  sel_victim;
   logic        sel_rr;

   // Lowest-index invalid way wins; the round-robin pointer is the fallback.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sel_victim = rr_ptr;
      sel_rr     = 1'b1;
      for (int w = 7; w >= 0; w--) begin
         if (!valid_q[w]) begin
            sel_victim = 3'(w);
            sel_rr     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (miss_req) state_nxt = SELECT;
         SELECT: begin
            if (valid_q[sel_victim] && dirty_q[sel_victim]) state_nxt = WRITEBACK;
            else if (wr_q)                                  state_nxt = FILL;
            else                                            state_nxt = FETCH;
         end
         WRITEBACK: if (mem_ack) state_nxt = wr_q ? FILL : FETCH;
         FETCH:     if (mem_ack) state_nxt = FILL;
         FILL:      state_nxt = DONE;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Datapath registers are cleared too, so every data/address output reads 0 after reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         tag_q     <= '0;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         valid_q   <= '0;
         dirty_q   <= '0;
         victim_q  <= '0;
         from_rr_q <= 1'b0;
         vtag_q    <= '0;
         vdata_q   <= '0;
         rdata_q   <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            IDLE: if (miss_req) begin
               tag_q   <= miss_addr[31:6];
               idx_q   <= miss_addr[5:2];
               wr_q    <= miss_is_write;
               wdata_q <= miss_wdata;
               valid_q <= valid_vec;
               dirty_q <= dirty_vec;
            end
            SELECT: begin
               victim_q  <= sel_victim;
               from_rr_q <= sel_rr;
               vtag_q    <= victim_tag;
               vdata_q   <= victim_data;
            end
            FETCH: if (mem_ack) rdata_q <= mem_rdata;
            FILL:  if (from_rr_q) rr_ptr <= rr_ptr + 3'd1;
            default: ;
         endcase
      end
   end

   assign victim_way    = (state == SELECT) ? sel_victim : victim_q;
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);

   assign mem_req       = (state == WRITEBACK) || (state == FETCH);
   assign mem_we        = (state == WRITEBACK);
   assign mem_addr      = (state == WRITEBACK) ? {vtag_q, idx_q, 2'b00} : {tag_q, idx_q, 2'b00};
   assign mem_wdata     = vdata_q;

   assign fill_we       = (state == FILL);
   assign fill_index    = idx_q;
   assign fill_way_oh   = fill_we ? (8'd1 << victim_q) : 8'd0;
   assign fill_tag      = tag_q;
   assign fill_halt_tag = tag_q[3:0];
   assign fill_data     = wr_q ? wdata_q : rdata_q;
   assign fill_valid    = fill_we;
   assign fill_dirty    = wr_q;

endmodule

// File: doc/cache_miss_controller.md
# cache_miss_controller

Miss-handling engine for the 8-way, 16-set cache (26-bit tag, 4-bit index, 2-bit byte offset, one 32-bit word per block). On a miss it picks a victim way, writes the victim back to memory if it is valid and dirty, then fetches the missing word (read miss) or takes the store data (write miss). It then issues a one-cycle fill into the tag, block, valid, dirty and halt-tag arrays. It is the memory-side counterpart of the lookup path: the lookup path reads the arrays and flags misses, and this block writes the arrays.

## Interface
Parameters: none (geometry fixed: 8 ways, 16 sets, 26-bit tag, 4-bit halt tag = tag[3:0]).
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- miss_req  in  1  miss present; sampled only in IDLE
- miss_addr  in  32  missing address: tag = [31:6], index = [5:2]
- miss_is_write  in  1  1 = store miss
- miss_wdata  in  32  store data for a write miss
- valid_vec  in  8  valid bits of the indexed set, bit n = way n
- dirty_vec  in  8  dirty bits of the indexed set
- victim_way  out  3  way whose tag/data the datapath must mux onto victim_tag/victim_data
- victim_tag  in  26  tag of way victim_way in the indexed set
- victim_data  in  32  block of way victim_way in the indexed set
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write-back, 0 = fetch
- mem_addr  out  32  word address; bits [1:0] always 0
- mem_wdata  out  32  write-back data
- mem_ack  in  1  transfer complete when mem_req & mem_ack at a rising edge
- mem_rdata  in  32  fetch data, valid with mem_ack
- fill_we  out  1  one-cycle array write strobe
- fill_index  out  4  set being filled
- fill_way_oh  out  8  one-hot way select (drives halt-tag write_enable, gated by fill_we)
- fill_tag  out  26  new tag
- fill_halt_tag  out  4  fill_tag[3:0]
- fill_data  out  32  new block word
- fill_valid  out  1  always 1 during fill
- fill_dirty  out  1  = latched miss_is_write
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; arrays are updated

## Operation
- States: IDLE, SELECT, WRITEBACK, FETCH, FILL, DONE.
- IDLE: on miss_req=1, latch the address, write flag, wdata, valid_vec and dirty_vec, then go to SELECT. miss_req in any other state is ignored, not queued.
- SELECT (1 cycle): the victim is the lowest-index way with latched valid=0. If all ways are valid, the victim is the round-robin pointer rr_ptr. victim_way is driven from this cycle until IDLE. Latch victim_tag and victim_data at the end of SELECT. Next state:
  - latched valid & dirty for the victim → WRITEBACK
  - else if write miss → FILL
  - else → FETCH
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim_tag, index, 2'b00}, mem_wdata=latched victim_data. On ack: FETCH for a read miss, FILL for a write miss.
- FETCH: mem_req=1, mem_we=0, mem_addr={miss tag, index, 2'b00}. On ack, latch mem_rdata and go to FILL.
- FILL (1 cycle): fill_we=1, with fill_way_oh = 1<<victim. fill_data is the fetched word (read miss) or miss_wdata (write miss). fill_dirty = write flag, fill_valid=1.
- DONE (1 cycle): done=1, then IDLE.
- rr_ptr (3-bit):
  - increments mod 8 in FILL only when the victim came from rr_ptr, i.e. all ways valid; 7 wraps to 0.
  - unchanged when an invalid way was chosen.
- Outputs outside their active states: mem_req, mem_we, fill_we and done are 0. Data and address outputs hold their last values and are don't-care.

## Timing
- Reset (synchronous, wins over everything):
  - State goes to IDLE and rr_ptr to 0.
  - All outputs go to 0: busy, done, mem_req, mem_we, fill_we, fill_way_oh, fill_valid, fill_dirty, victim_way, mem_addr, mem_wdata, fill_* buses.
  - Reset mid-transfer drops mem_req after that edge. The memory side must discard the aborted transfer.
  - No fill occurs for the aborted miss.
- Edges: miss_req sampled at edge E0 → SELECT during cycle E0–E1, busy=1.
- Clean read miss with mem_ack high in the first FETCH cycle:
  - FETCH cycle 2
  - FILL cycle 3
  - done in cycle 4
  - IDLE after E4
- Each extra ack-wait cycle adds one cycle. A write-back adds one or more cycles (minimum one).
- Clean write miss: SELECT, FILL, DONE; done in cycle 3. No memory traffic.
- mem_req rises the cycle after entering WRITEBACK or FETCH is registered. It stays high with stable mem_addr, mem_we and mem_wdata until the edge at which mem_ack=1. mem_ack while mem_req=0 is ignored.
- Dirty read miss: two separate transactions, each needing its own ack. mem_req may stay high across the boundary; mem_we and mem_addr change at the first ack edge.
- Arrays latch on the falling clk edge inside the FILL cycle. Lookup may reuse the set from the done cycle.

## Test plan
- Reset: assert reset for 2 cycles mid-operation → all outputs 0, busy=0, rr_ptr=0; next all-valid miss selects way 0.
- Clean read miss: valid_vec=8'b11111011, addr=0x0000_1234, ack immediate →
  - victim_way=2
  - mem read addr 0x0000_1234
  - fill_way_oh=8'b00000100
  - fill_tag=0x000048, fill_halt_tag=4'h8
  - fill_dirty=0
  - done 4 cycles after request
- Dirty victim: valid=8'hFF, dirty=8'h01, rr_ptr=0, victim_tag=0x3FFFFFF, victim_data=0xDEADBEEF, addr index 5, read miss →
  - write-back to mem_addr 0xFFFFFFD4 with wdata 0xDEADBEEF
  - then fetch; fill with mem_rdata
  - rr_ptr=1 afterward
- Write miss clean: valid=8'h00, miss_is_write=1, wdata=0x12345678 →
  - no mem_req
  - fill way 0, fill_data=0x12345678, fill_dirty=1
  - done in cycle 3
- Round-robin wrap: 9 successive all-valid clean read misses → victims 0,1,…,7,0.
- Delayed ack plus ignored request: ack after 3 wait cycles with miss_req held high →
  - mem_req/mem_addr stable for 4 cycles
  - exactly one fill
  - new miss accepted only in IDLE
